alu1_issue_queue: RTL and testbench
===================================

Name: alu1_issue_queue

Overview:
- Issue-side feeder for execution port 1 (ALU1). It is the producer of the EX_ALU1 instruction bus that the execute port consumes.
- Buffers issued ALU1 micro-ops in a small in-order FIFO and presents the head to the execute port.
- Holds the head while the execute port asserts lock (divider result occupying the writeback slot).
- Caps outstanding divides to the execute port's divide-tracking depth, and flushes on iFREE_EX.

Parameters:
DEPTH, 4, FIFO entries (power of two)
DEPTH_N, 2, log2(DEPTH)
DIV_MAX, 16, max divides in flight inside execute port (its condition-FIFO depth)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  async active-low reset
iFREE_EX  in  1  pipeline flush
iISSUE_VALID  in  1  scheduler issues one micro-op
iISSUE_DATA  in  99  packed micro-op, layout per package (fields below)
oISSUE_LOCK  out  1  queue full; scheduler must not issue
iEX_ALU1_LOCK  in  1  execute port busy with divider output; hold head
iDIV_DONE  in  1  one divide result retired from execute port
oEX_ALU1_VALID  out  1  head micro-op presented and consumed this cycle
oEX_ALU1_WRITEBACK  out  1  result writeback enable
oEX_ALU1_COMMIT_TAG  out  6  commit tag
oEX_ALU1_CMD  out  5  unit command
oEX_ALU1_AFE  out  4  AFE field
oEX_ALU1_UNIT  out  7  one-hot {SYS_REG,LOGIC,SHIFT,ADDER,MUL,SDIV,UDIV}
oEX_ALU1_SOURCE0  out  32  operand 0
oEX_ALU1_SOURCE1  out  32  operand 1
oEX_ALU1_DESTINATION_SYSREG  out  1  destination is system register
oEX_ALU1_DESTINATION_REGNAME  out  6  destination register
oEX_ALU1_FLAGS_WRITEBACK  out  1  flags writeback enable
oEX_ALU1_FLAGS_REGNAME  out  4  flags register
oDIV_OUTSTANDING  out  5  divides in flight (debug/perf)

Behaviour:
- Reset: inRESET is asynchronous, active-low, clock iCLOCK. Pointers, count, div counter and all storage go to 0. oISSUE_LOCK=0, oEX_ALU1_VALID=0, all payload outputs 0, oDIV_OUTSTANDING=0.
- Push: iISSUE_VALID && !oISSUE_LOCK writes iISSUE_DATA at wr_ptr. wr_ptr wraps modulo DEPTH.
- oISSUE_LOCK is the registered condition count==DEPTH. A push while full is ignored; the scheduler contract forbids it.
- Latency: an accepted entry is visible at the output at earliest the cycle after the push. There is no same-cycle bypass.
- Payload outputs always show the head entry (storage[rd_ptr]), including when not valid.
- div_head = head UNIT[1] | UNIT[0].
- div_block = div_head && div_cnt==DIV_MAX.
- oEX_ALU1_VALID = (count!=0) && !iEX_LOCK && !div_block && !iFREE_EX. This is combinational from registered state plus the iEX_ALU1_LOCK / iFREE_EX inputs.
- Pop: oEX_ALU1_VALID asserted means the execute port latched the entry. rd_ptr increments, modulo DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- div_cnt:
  - +1 on pop of a div_head entry.
  - -1 on iDIV_DONE.
  - Both in the same cycle: unchanged.
  - iDIV_DONE with div_cnt==0 is ignored, with no underflow.
  - Never exceeds DIV_MAX.
- Blocking is strictly in order. A blocked divide at the head also stalls any non-div entries behind it.
- iFREE_EX (synchronous, highest priority after reset):
  - Next cycle: count=0, pointers=0, div_cnt=0.
  - A push in the same cycle is discarded.
  - oEX_ALU1_VALID is forced 0 during the flush cycle.
- Count width is DEPTH_N+1 bits. Full is count==DEPTH; empty is count==0.

Decomposition:
- Shared package/header (core.h) holds:
  - the ALU1 micro-op field offsets and widths (ALU1_UOP_W=99, order MSB→LSB: WRITEBACK, COMMIT_TAG, CMD, AFE, UNIT[6:0], SOURCE0, SOURCE1, DEST_SYSREG, DEST_REGNAME, FLAGS_WRITEBACK, FLAGS_REGNAME);
  - the UNIT bit indices.
- One natural sub-module: the existing sync_fifo (N=99, DEPTH, DEPTH_N) as storage with iREMOVE=iFREE_EX. The read-side gating and div counter stay in this block.

Test Plan:
- Push 4 ADD ops, tags 1..4, iEX_ALU1_LOCK=0 → VALID on 4 consecutive cycles starting 1 cycle after the first push, tags in order 1,2,3,4; oISSUE_LOCK never asserts.
- Push 4 ops while iEX_ALU1_LOCK=1 held → oISSUE_LOCK=1 after the 4th push; 5th issue is ignored. Release lock → 4 pops, and oISSUE_LOCK drops the cycle after the first pop.
- Issue 16 UDIV then 1 SDIV then 1 ADD, iDIV_DONE=0 → 16 pops, oDIV_OUTSTANDING=16, SDIV held with VALID=0. Pulse iDIV_DONE once → SDIV pops the next cycle, then ADD; counter returns to 16.
- iDIV_DONE coincident with a div pop at div_cnt=5 → stays 5. iDIV_DONE at div_cnt=0 → stays 0.
- Queue holding 3 entries, assert iFREE_EX together with iISSUE_VALID → VALID=0 that cycle; next cycle count=0, oDIV_OUTSTANDING=0, and the new entry is absent.
- Assert inRESET low mid-stream with 2 entries queued → all outputs 0 immediately (asynchronous); after release, VALID stays 0 until a new push.

Source files
------------

// File: rtl/alu1_issue_queue_pkg.sv
// Shared ALU1 micro-op layout: field widths, bit offsets and execution-unit bit indices.
// The packed struct below is the single source of truth for the 99-bit issue bus.
package alu1_issue_queue_pkg;

    localparam int ALU1_UOP_W = 99;

    // Unit one-hot bit indices, MSB..LSB = {SYS_REG,LOGIC,SHIFT,ADDER,MUL,SDIV,UDIV}
    localparam int UNIT_UDIV    = 0;
    localparam int UNIT_SDIV    = 1;
    localparam int UNIT_MUL     = 2;
    localparam int UNIT_ADDER   = 3;
    localparam int UNIT_SHIFT   = 4;
    localparam int UNIT_LOGIC   = 5;
    localparam int UNIT_SYS_REG = 6;

    // LSB offsets of each field inside the packed micro-op
    localparam int OFF_FLAGS_REGNAME   = 0;
    localparam int OFF_FLAGS_WRITEBACK = 4;
    localparam int OFF_DEST_REGNAME    = 5;
    localparam int OFF_DEST_SYSREG     = 11;
    localparam int OFF_SOURCE1         = 12;
    localparam int OFF_SOURCE0         = 44;
    localparam int OFF_UNIT            = 76;
    localparam int OFF_AFE             = 83;
    localparam int OFF_CMD             = 87;
    localparam int OFF_COMMIT_TAG      = 92;
    localparam int OFF_WRITEBACK       = 98;

    typedef struct packed {
        logic        writeback;
        logic [5:0]  commit_tag;
        logic [4:0]  cmd;
        logic [3:0]  afe;
        logic [6:0]  unit;
        logic [31:0] source0;
        logic [31:0] source1;
        logic        dest_sysreg;
        logic [5:0]  dest_regname;
        logic        flags_writeback;
        logic [3:0]  flags_regname;
    } alu1_uop_t;

    function automatic logic is_div(input logic [6:0] unit);
        return unit[UNIT_SDIV] | unit[UNIT_UDIV];
    endfunction

endpackage

// File: rtl/alu1_issue_queue_sync_fifo.sv
// Synchronous in-order FIFO with a synchronous clear (iREMOVE) that wins over push/pop.
// Read data always reflects the entry at the read pointer; no write-to-read bypass.
module alu1_issue_queue_sync_fifo #(
    parameter int N       = 99,
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic           iREMOVE,
    input  logic           iWR_EN,
    input  logic [N-1:0]   iWR_DATA,
    input  logic           iRD_EN,
    output logic [N-1:0]   oRD_DATA,
    output logic           oFULL,
    output logic           oEMPTY
);

    localparam logic [DEPTH_N:0] FULL_CNT = (DEPTH_N+1)'(DEPTH);

    logic [N-1:0]       mem_q [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_N:0]   count_q, count_d;
    logic               wr_fire, rd_fire;

    assign oFULL    = (count_q == FULL_CNT);
    assign oEMPTY   = (count_q == '0);
    assign oRD_DATA = mem_q[rd_ptr_q];

    // A push into a full queue is dropped, as is a pop from an empty one.
    assign wr_fire = iWR_EN && !oFULL;
    assign rd_fire = iRD_EN && !oEMPTY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iREMOVE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_fire && !rd_fire)      count_d = count_q + 1'b1;
            else if (!wr_fire && rd_fire) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_fire && !iREMOVE) mem_q[wr_ptr_q] <= iWR_DATA;
        end
    end

endmodule

// File: rtl/alu1_issue_queue.sv
// ALU1 issue queue: buffers issued micro-ops and feeds the EX_ALU1 bus in order, holding
// the head on execute lock or when the execute port already tracks DIV_MAX divides.
// Handshake: oEX_ALU1_VALID high means the execute port took the head this cycle (no ready).
module alu1_issue_queue
    import alu1_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2,
    parameter int DIV_MAX = 16
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFREE_EX,
    input  logic        iISSUE_VALID,
    input  logic [98:0] iISSUE_DATA,
    output logic        oISSUE_LOCK,
    input  logic        iEX_ALU1_LOCK,
    input  logic        iDIV_DONE,
    output logic        oEX_ALU1_VALID,
    output logic        oEX_ALU1_WRITEBACK,
    output logic [5:0]  oEX_ALU1_COMMIT_TAG,
    output logic [4:0]  oEX_ALU1_CMD,
    output logic [3:0]  oEX_ALU1_AFE,
    output logic [6:0]  oEX_ALU1_UNIT,
    output logic [31:0] oEX_ALU1_SOURCE0,
    output logic [31:0] oEX_ALU1_SOURCE1,
    output logic        oEX_ALU1_DESTINATION_SYSREG,
    output logic [5:0]  oEX_ALU1_DESTINATION_REGNAME,
    output logic        oEX_ALU1_FLAGS_WRITEBACK,
    output logic [3:0]  oEX_ALU1_FLAGS_REGNAME,
    output logic [4:0]  oDIV_OUTSTANDING
);

    localparam logic [4:0] DIV_MAX_C = 5'(DIV_MAX);

    logic [ALU1_UOP_W-1:0] head_raw;
    alu1_uop_t             head;
    logic                  fifo_full, fifo_empty;
    logic                  div_head, div_block, pop;
    logic                  div_inc, div_dec;
    logic [4:0]            div_cnt_q, div_cnt_d;

    alu1_issue_queue_sync_fifo #(
        .N       (ALU1_UOP_W),
        .DEPTH   (DEPTH),
        .DEPTH_N (DEPTH_N)
    ) u_fifo (
        .iCLOCK   (iCLOCK),
        .inRESET  (inRESET),
        .iREMOVE  (iFREE_EX),
        .iWR_EN   (iISSUE_VALID),
        .iWR_DATA (iISSUE_DATA),
        .iRD_EN   (pop),
        .oRD_DATA (head_raw),
        .oFULL    (fifo_full),
        .oEMPTY   (fifo_empty)
    );

    assign head      = alu1_uop_t'(head_raw);
    assign div_head  = is_div(head.unit);
    assign div_block = div_head && (div_cnt_q == DIV_MAX_C);

    // Strictly in-order: a blocked divide at the head stalls everything behind it.
    assign pop = !fifo_empty && !iEX_ALU1_LOCK && !div_block && !iFREE_EX;

    assign div_inc = pop && div_head;
    assign div_dec = iDIV_DONE && (div_cnt_q != '0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (iFREE_EX)                div_cnt_d = '0;
        else if (div_inc && !div_dec) div_cnt_d = div_cnt_q + 1'b1;
        else if (!div_inc && div_dec) div_cnt_d = div_cnt_q - 1'b1;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) div_cnt_q <= '0;
        else          div_cnt_q <= div_cnt_d;
    end

    assign oISSUE_LOCK                  = fifo_full;
    assign oEX_ALU1_VALID               = pop;
    assign oDIV_OUTSTANDING             = div_cnt_q;
    assign oEX_ALU1_WRITEBACK           = head.writeback;
    assign oEX_ALU1_COMMIT_TAG          = head.commit_tag;
    assign oEX_ALU1_CMD                 = head.cmd;
    assign oEX_ALU1_AFE                 = head.afe;
    assign oEX_ALU1_UNIT                = head.unit;
    assign oEX_ALU1_SOURCE0             = head.source0;
    assign oEX_ALU1_SOURCE1             = head.source1;
    assign oEX_ALU1_DESTINATION_SYSREG  = head.dest_sysreg;
    assign oEX_ALU1_DESTINATION_REGNAME = head.dest_regname;
    assign oEX_ALU1_FLAGS_WRITEBACK     = head.flags_writeback;
    assign oEX_ALU1_FLAGS_REGNAME       = head.flags_regname;

endmodule

// File: tb/tb_alu1_issue_queue.sv
// Directed bench for alu1_issue_queue: stimulus pushes expected micro-ops into exp_q,
// a negedge monitor pops and compares whenever the DUT presents a valid head.
module tb_alu1_issue_queue;
    import alu1_issue_queue_pkg::*;

    localparam logic [6:0] U_ADD  = 7'b0001000;
    localparam logic [6:0] U_UDIV = 7'b0000001;
    localparam logic [6:0] U_SDIV = 7'b0000010;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iFREE_EX = 1'b0;
    logic        iISSUE_VALID = 1'b0;
    logic [98:0] iISSUE_DATA = '0;
    logic        oISSUE_LOCK;
    logic        iEX_ALU1_LOCK = 1'b0;
    logic        iDIV_DONE = 1'b0;
    logic        oEX_ALU1_VALID;
    logic        oEX_ALU1_WRITEBACK;
    logic [5:0]  oEX_ALU1_COMMIT_TAG;
    logic [4:0]  oEX_ALU1_CMD;
    logic [3:0]  oEX_ALU1_AFE;
    logic [6:0]  oEX_ALU1_UNIT;
    logic [31:0] oEX_ALU1_SOURCE0;
    logic [31:0] oEX_ALU1_SOURCE1;
    logic        oEX_ALU1_DESTINATION_SYSREG;
    logic [5:0]  oEX_ALU1_DESTINATION_REGNAME;
    logic        oEX_ALU1_FLAGS_WRITEBACK;
    logic [3:0]  oEX_ALU1_FLAGS_REGNAME;
    logic [4:0]  oDIV_OUTSTANDING;

    logic [98:0] exp_q[$];
    logic [98:0] mon_got, mon_exp, payload;
    int          tests = 0;
    int          fails = 0;
    int          pops  = 0;

    alu1_issue_queue dut (
        .iCLOCK                       (iCLOCK),
        .inRESET                      (inRESET),
        .iFREE_EX                     (iFREE_EX),
        .iISSUE_VALID                 (iISSUE_VALID),
        .iISSUE_DATA                  (iISSUE_DATA),
        .oISSUE_LOCK                  (oISSUE_LOCK),
        .iEX_ALU1_LOCK                (iEX_ALU1_LOCK),
        .iDIV_DONE                    (iDIV_DONE),
        .oEX_ALU1_VALID               (oEX_ALU1_VALID),
        .oEX_ALU1_WRITEBACK           (oEX_ALU1_WRITEBACK),
        .oEX_ALU1_COMMIT_TAG          (oEX_ALU1_COMMIT_TAG),
        .oEX_ALU1_CMD                 (oEX_ALU1_CMD),
        .oEX_ALU1_AFE                 (oEX_ALU1_AFE),
        .oEX_ALU1_UNIT                (oEX_ALU1_UNIT),
        .oEX_ALU1_SOURCE0             (oEX_ALU1_SOURCE0),
        .oEX_ALU1_SOURCE1             (oEX_ALU1_SOURCE1),
        .oEX_ALU1_DESTINATION_SYSREG  (oEX_ALU1_DESTINATION_SYSREG),
        .oEX_ALU1_DESTINATION_REGNAME (oEX_ALU1_DESTINATION_REGNAME),
        .oEX_ALU1_FLAGS_WRITEBACK     (oEX_ALU1_FLAGS_WRITEBACK),
        .oEX_ALU1_FLAGS_REGNAME       (oEX_ALU1_FLAGS_REGNAME),
        .oDIV_OUTSTANDING             (oDIV_OUTSTANDING)
    );

    // clock / reset
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    assign payload = {oEX_ALU1_WRITEBACK, oEX_ALU1_COMMIT_TAG, oEX_ALU1_CMD, oEX_ALU1_AFE,
                      oEX_ALU1_UNIT, oEX_ALU1_SOURCE0, oEX_ALU1_SOURCE1,
                      oEX_ALU1_DESTINATION_SYSREG, oEX_ALU1_DESTINATION_REGNAME,
                      oEX_ALU1_FLAGS_WRITEBACK, oEX_ALU1_FLAGS_REGNAME};

    function automatic logic [98:0] mk(input logic [5:0] tag, input logic [6:0] unit);
        alu1_uop_t m;
        m.writeback       = 1'b1;
        m.commit_tag      = tag;
        m.cmd             = tag[4:0] ^ 5'h15;
        m.afe             = tag[3:0];
        m.unit            = unit;
        m.source0         = 32'hA500_0000 | 32'(tag);
        m.source1         = 32'h5A00_0000 | (32'(tag) << 8);
        m.dest_sysreg     = tag[0];
        m.dest_regname    = ~tag;
        m.flags_writeback = tag[1];
        m.flags_regname   = tag[3:0] ^ 4'hF;
        return m;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic issue(input logic v, input logic [98:0] d, input logic accept);
        iISSUE_VALID = v;
        iISSUE_DATA  = d;
        if (v && accept) exp_q.push_back(d);
    endtask

    task automatic chk(input string name, input logic [98:0] got, input logic [98:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge iCLOCK) begin
        if (inRESET === 1'b1 && oEX_ALU1_VALID === 1'b1) begin
            mon_got = payload;
            pops++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected got=%0h exp=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL pop_payload got=%0h exp=%0h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (2) tick();
        @(negedge iCLOCK);
        chk("rst_valid", oEX_ALU1_VALID, 0);
        chk("rst_lock", oISSUE_LOCK, 0);
        chk("rst_div", oDIV_OUTSTANDING, 0);
        chk("rst_payload", payload, 0);
        tick();
        inRESET = 1'b1;

        // 4 ADDs streamed, no bypass, one pop per cycle
        for (int i = 0; i < 4; i++) begin
            issue(1, mk(6'(1 + i), U_ADD), 1);
            @(negedge iCLOCK);
            chk("s1_valid", oEX_ALU1_VALID, (i > 0));
            chk("s1_lock", oISSUE_LOCK, 0);
            tick();
        end
        issue(0, '0, 0);
        @(negedge iCLOCK);
        chk("s1_last_valid", oEX_ALU1_VALID, 1);
        chk("s1_last_lock", oISSUE_LOCK, 0);
        tick();
        @(negedge iCLOCK);
        chk("s1_empty", oEX_ALU1_VALID, 0);
        tick();

        // fill under execute lock, 5th issue ignored
        iEX_ALU1_LOCK = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1, mk(6'(5 + i), U_ADD), 1);
            @(negedge iCLOCK);
            chk("s2_hold", oEX_ALU1_VALID, 0);
            chk("s2_lock_fill", oISSUE_LOCK, 0);
            tick();
        end
        issue(1, mk(6'd61, U_ADD), 0);
        @(negedge iCLOCK);
        chk("s2_full_lock", oISSUE_LOCK, 1);
        chk("s2_full_valid", oEX_ALU1_VALID, 0);
        tick();
        issue(0, '0, 0);
        iEX_ALU1_LOCK = 1'b0;
        @(negedge iCLOCK);
        chk("s2_pop1_valid", oEX_ALU1_VALID, 1);
        chk("s2_pop1_lock", oISSUE_LOCK, 1);
        tick();
        @(negedge iCLOCK);
        chk("s2_lock_drop", oISSUE_LOCK, 0);
        chk("s2_pop2_valid", oEX_ALU1_VALID, 1);
        tick();
        repeat (2) tick();
        @(negedge iCLOCK);
        chk("s2_drained", oEX_ALU1_VALID, 0);
        chk("s2_pops", 99'(pops), 8);

        // divide cap: 16 UDIV pass, SDIV held until one divide retires
        for (int i = 0; i < 16; i++) begin
            issue(1, mk(6'(10 + i), U_UDIV), 1);
            tick();
        end
        issue(1, mk(6'd26, U_SDIV), 1);
        tick();
        issue(1, mk(6'd27, U_ADD), 1);
        tick();
        issue(0, '0, 0);
        repeat (2) tick();
        @(negedge iCLOCK);
        chk("s3_blocked", oEX_ALU1_VALID, 0);
        chk("s3_div16", oDIV_OUTSTANDING, 16);
        chk("s3_lock", oISSUE_LOCK, 0);
        chk("s3_head_sdiv", payload, mk(6'd26, U_SDIV));
        tick();
        iDIV_DONE = 1'b1;
        @(negedge iCLOCK);
        chk("s3_done_cycle", oEX_ALU1_VALID, 0);
        tick();
        iDIV_DONE = 1'b0;
        @(negedge iCLOCK);
        chk("s3_sdiv_pop", oEX_ALU1_VALID, 1);
        chk("s3_div15", oDIV_OUTSTANDING, 15);
        tick();
        @(negedge iCLOCK);
        chk("s3_add_pop", oEX_ALU1_VALID, 1);
        chk("s3_div16b", oDIV_OUTSTANDING, 16);
        tick();
        @(negedge iCLOCK);
        chk("s3_drained", oEX_ALU1_VALID, 0);
        chk("s3_div16c", oDIV_OUTSTANDING, 16);
        tick();

        // flush clears div counter; then coincident done+div pop at 5
        iFREE_EX = 1'b1;
        exp_q.delete();
        @(negedge iCLOCK);
        chk("s4_flush_valid", oEX_ALU1_VALID, 0);
        tick();
        iFREE_EX = 1'b0;
        @(negedge iCLOCK);
        chk("s4_flush_div", oDIV_OUTSTANDING, 0);
        for (int i = 0; i < 6; i++) begin
            issue(1, mk(6'(30 + i), U_UDIV), 1);
            tick();
        end
        issue(0, '0, 0);
        iDIV_DONE = 1'b1;
        @(negedge iCLOCK);
        chk("s4_coinc_valid", oEX_ALU1_VALID, 1);
        chk("s4_div5", oDIV_OUTSTANDING, 5);
        tick();
        iDIV_DONE = 1'b0;
        @(negedge iCLOCK);
        chk("s4_div5_hold", oDIV_OUTSTANDING, 5);
        chk("s4_idle", oEX_ALU1_VALID, 0);
        for (int k = 0; k < 5; k++) begin
            iDIV_DONE = 1'b1;
            tick();
        end
        iDIV_DONE = 1'b0;
        @(negedge iCLOCK);
        chk("s4_div0", oDIV_OUTSTANDING, 0);
        iDIV_DONE = 1'b1;
        tick();
        iDIV_DONE = 1'b0;
        @(negedge iCLOCK);
        chk("s4_no_underflow", oDIV_OUTSTANDING, 0);
        tick();

        // flush with 3 queued and a same-cycle push
        for (int i = 0; i < 2; i++) begin
            issue(1, mk(6'(36 + i), U_UDIV), 1);
            tick();
        end
        issue(0, '0, 0);
        repeat (2) tick();
        @(negedge iCLOCK);
        chk("s5_div2", oDIV_OUTSTANDING, 2);
        iEX_ALU1_LOCK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1, mk(6'(38 + i), U_ADD), 1);
            tick();
        end
        iEX_ALU1_LOCK = 1'b0;
        iFREE_EX      = 1'b1;
        exp_q.delete();
        issue(1, mk(6'd60, U_ADD), 0);
        @(negedge iCLOCK);
        chk("s5_flush_valid", oEX_ALU1_VALID, 0);
        tick();
        iFREE_EX = 1'b0;
        issue(0, '0, 0);
        @(negedge iCLOCK);
        chk("s5_post_valid", oEX_ALU1_VALID, 0);
        chk("s5_post_div", oDIV_OUTSTANDING, 0);
        chk("s5_post_lock", oISSUE_LOCK, 0);
        tick();
        @(negedge iCLOCK);
        chk("s5_still_empty", oEX_ALU1_VALID, 0);
        tick();
        issue(1, mk(6'd41, U_ADD), 1);
        tick();
        issue(0, '0, 0);
        @(negedge iCLOCK);
        chk("s5_new_valid", oEX_ALU1_VALID, 1);
        tick();
        @(negedge iCLOCK);
        chk("s5_new_done", oEX_ALU1_VALID, 0);
        tick();

        // asynchronous reset mid-stream
        issue(1, mk(6'd42, U_UDIV), 1);
        tick();
        issue(0, '0, 0);
        tick();
        iEX_ALU1_LOCK = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(1, mk(6'(43 + i), U_ADD), 1);
            tick();
        end
        issue(0, '0, 0);
        @(negedge iCLOCK);
        chk("s6_pre_div", oDIV_OUTSTANDING, 1);
        chk("s6_pre_head", payload, mk(6'd43, U_ADD));
        @(posedge iCLOCK);
        #2;
        inRESET = 1'b0;
        exp_q.delete();
        #1;
        chk("s6_rst_valid", oEX_ALU1_VALID, 0);
        chk("s6_rst_lock", oISSUE_LOCK, 0);
        chk("s6_rst_div", oDIV_OUTSTANDING, 0);
        chk("s6_rst_payload", payload, 0);
        tick();
        inRESET       = 1'b1;
        iEX_ALU1_LOCK = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLOCK);
            chk("s6_idle_valid", oEX_ALU1_VALID, 0);
            tick();
        end
        issue(1, mk(6'd45, U_ADD), 1);
        tick();
        issue(0, '0, 0);
        @(negedge iCLOCK);
        chk("s6_new_valid", oEX_ALU1_VALID, 1);
        tick();
        repeat (2) tick();

        // final report
        chk("final_exp_q_empty", 99'(exp_q.size()), 0);
        chk("final_pop_count", 99'(pops), 37);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
